// File: rtl/xnor_popcount_acc.sv
// Binary-conv column accumulator: sums masked XNOR match bits over a window of
// kernel columns, then presents the match count and its thresholded activation.

// Popcount of one kernel column after row masking.
module xnor_popcnt_col #(
  parameter int ROWS = 7,
  parameter int CW   = 3
) (
  input  logic [ROWS-1:0] bits,
  input  logic [ROWS-1:0] mask,
  output logic [CW-1:0]   count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < ROWS; i++) count = count + CW'(bits[i] & mask[i]);
  end
endmodule

module xnor_popcount_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] xnor_in,
  input  logic [2:0] height,
  input  logic [2:0] width,
  input  logic [5:0] threshold,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] pop_out,
  output logic       bin_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [5:0] acc;
  logic [2:0] beat_cnt;
  logic [2:0] height_q, width_q;
  logic [5:0] thr_q;

  logic       accept, last_beat;
  logic [2:0] cur_height, cur_width, eff_width;
  logic [5:0] cur_thr, sum;
  logic [6:0] row_mask;
  logic [2:0] col_cnt;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // First beat of a window takes its config straight from the ports.
  assign eff_width  = (width == 3'd0) ? 3'd1 : width;
  assign cur_height = (state == IDLE) ? height    : height_q;
  assign cur_width  = (state == IDLE) ? eff_width : width_q;
  assign cur_thr    = (state == IDLE) ? threshold : thr_q;

  always_comb begin
    case (cur_height)
      3'd1:    row_mask = 7'h01;
      3'd3:    row_mask = 7'h07;
      3'd5:    row_mask = 7'h1F;
      default: row_mask = 7'h7F;
    endcase
  end

  xnor_popcnt_col #(.ROWS(7), .CW(3)) u_col (
    .bits  (xnor_in),
    .mask  (row_mask),
    .count (col_cnt)
  );

  assign sum       = acc + {3'b000, col_cnt};
  assign last_beat = ((beat_cnt + 3'd1) == cur_width);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      height_q <= '0;
      width_q  <= '0;
      thr_q    <= '0;
      pop_out  <= '0;
      bin_out  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            if (state == IDLE) begin
              height_q <= height;
              width_q  <= eff_width;
              thr_q    <= threshold;
            end
            acc <= sum;
            if (last_beat) begin
              pop_out <= sum;
              bin_out <= (sum >= cur_thr);
              state   <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
              state    <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state    <= IDLE;
            acc      <= '0;
            beat_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
